// File: rtl/fpu_div_pkg.sv
// Shared types and constants for the FP divide control sequencer.
package fpu_div_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StD1,
    StD2,
    StD3,
    StD4,
    StIter,
    StD5,
    StD6,
    StD7,
    StDone
  } div_state_e;

  localparam int unsigned IterDbl = 55;
  localparam int unsigned IterSng = 26;
  localparam int unsigned TagW    = 5;
  localparam int unsigned CntW    = 6;

  // Accept-edge-relative cycle of the first result-valid.
  localparam int unsigned LatDbl     = IterDbl + 8;
  localparam int unsigned LatSng     = IterSng + 8;
  localparam int unsigned LatSpecial = 8;

endpackage

// File: rtl/fpu_div_seq_if.sv
// Request, strobe and result signals between the divide sequencer and its neighbours.
interface fpu_div_seq_if
  import fpu_div_pkg::*;
#(
  parameter int unsigned TAG_W = TagW
) ();
  logic             inq_div_vld;
  logic             inq_div_dbl;
  logic             inq_div_special;
  logic [TAG_W-1:0] inq_div_tag;
  logic             div_out_rdy;
  logic             div_busy;
  logic             d1stg_step;
  logic             div_expadd1_in1_dbl;
  logic             div_expadd1_in1_sng;
  logic             div_expadd1_in2_exp_in2_dbl;
  logic             div_expadd1_in2_exp_in2_sng;
  logic             d234stg_fdiv;
  logic             d3stg_fdiv;
  logic             d4stg_fdiv;
  logic             div_exp1_expadd1;
  logic             div_exp1_load;
  logic             d5stg_fdiva;
  logic             d5stg_fdivd;
  logic             d5stg_fdivs;
  logic             d6stg_fdiv;
  logic             d7stg_fdiv;
  logic             d7stg_fdivd;
  logic             div_iter;
  logic             fdiv_clken_l;
  logic             div_out_vld;
  logic [TAG_W-1:0] div_out_tag;

  modport master (
    output inq_div_vld, inq_div_dbl, inq_div_special, inq_div_tag, div_out_rdy,
    input  div_busy, d1stg_step, div_expadd1_in1_dbl, div_expadd1_in1_sng,
           div_expadd1_in2_exp_in2_dbl, div_expadd1_in2_exp_in2_sng, d234stg_fdiv,
           d3stg_fdiv, d4stg_fdiv, div_exp1_expadd1, div_exp1_load, d5stg_fdiva,
           d5stg_fdivd, d5stg_fdivs, d6stg_fdiv, d7stg_fdiv, d7stg_fdivd, div_iter,
           fdiv_clken_l, div_out_vld, div_out_tag
  );

  modport slave (
    input  inq_div_vld, inq_div_dbl, inq_div_special, inq_div_tag, div_out_rdy,
    output div_busy, d1stg_step, div_expadd1_in1_dbl, div_expadd1_in1_sng,
           div_expadd1_in2_exp_in2_dbl, div_expadd1_in2_exp_in2_sng, d234stg_fdiv,
           d3stg_fdiv, d4stg_fdiv, div_exp1_expadd1, div_exp1_load, d5stg_fdiva,
           d5stg_fdivd, d5stg_fdivs, d6stg_fdiv, d7stg_fdiv, d7stg_fdivd, div_iter,
           fdiv_clken_l, div_out_vld, div_out_tag
  );
endinterface

// File: rtl/fpu_div_iter_cnt.sv
// Loadable down-counter pacing the fraction loop; zero marks the last iteration.
module fpu_div_iter_cnt
  import fpu_div_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic [CntW-1:0] load_val,
  input  logic            dec,
  output logic            zero
);
  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);
endmodule

// File: rtl/fpu_div_seq.sv
// Control sequencer for the FP divide pipe: D1-D4, fraction loop, D5-D7, then result hold.
module fpu_div_seq
  import fpu_div_pkg::*;
#(
  parameter int unsigned ITER_DBL = IterDbl,
  parameter int unsigned ITER_SNG = IterSng,
  parameter int unsigned TAG_W    = TagW
) (
  input logic           rclk,
  input logic           reset,
  fpu_div_seq_if.slave  bus
);
  localparam logic [CntW-1:0] IterDblM1 = CntW'(ITER_DBL - 1);
  localparam logic [CntW-1:0] IterSngM1 = CntW'(ITER_SNG - 1);

  div_state_e       state_q;
  logic             dbl_q;
  logic             special_q;
  logic [TAG_W-1:0] tag_q;
  logic             vld_q;
  logic             cnt_zero;
  logic             cnt_load;
  logic             cnt_dec;

  always_ff @(posedge rclk) begin
    if (reset) begin
      state_q   <= StIdle;
      dbl_q     <= 1'b0;
      special_q <= 1'b0;
      tag_q     <= '0;
      vld_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.inq_div_vld) begin
            dbl_q     <= bus.inq_div_dbl;
            special_q <= bus.inq_div_special;
            tag_q     <= bus.inq_div_tag;
            state_q   <= StD1;
          end
        end
        StD1:   state_q <= StD2;
        StD2:   state_q <= StD3;
        StD3:   state_q <= StD4;
        StD4:   state_q <= special_q ? StD5 : StIter;
        StIter: if (cnt_zero) state_q <= StD5;
        StD5:   state_q <= StD6;
        StD6:   state_q <= StD7;
        StD7: begin
          state_q <= StDone;
          vld_q   <= 1'b1;
        end
        StDone: begin
          if (bus.div_out_rdy) begin
            state_q <= StIdle;
            vld_q   <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Loaded with N-1 on the D4->ITER edge so ITER lasts exactly N cycles.
  assign cnt_load = (state_q == StD4) && !special_q;
  assign cnt_dec  = (state_q == StIter) && !cnt_zero;

  fpu_div_iter_cnt u_iter_cnt (
    .clk      (rclk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (dbl_q ? IterDblM1 : IterSngM1),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  assign bus.div_busy                    = (state_q != StIdle);
  assign bus.d1stg_step                  = (state_q == StIdle) && bus.inq_div_vld;
  assign bus.div_expadd1_in1_dbl         = (state_q == StD1) && dbl_q;
  assign bus.div_expadd1_in1_sng         = (state_q == StD1) && !dbl_q;
  assign bus.div_expadd1_in2_exp_in2_dbl = (state_q == StD2) && dbl_q;
  assign bus.div_expadd1_in2_exp_in2_sng = (state_q == StD2) && !dbl_q;
  assign bus.d234stg_fdiv                = (state_q == StD2) || (state_q == StD3) ||
                                           (state_q == StD4);
  assign bus.d3stg_fdiv                  = (state_q == StD3);
  assign bus.d4stg_fdiv                  = (state_q == StD4);
  assign bus.div_exp1_expadd1            = (state_q == StD1) || bus.d234stg_fdiv;
  assign bus.div_exp1_load               = (state_q == StD1) || bus.d234stg_fdiv;
  assign bus.d5stg_fdiva                 = (state_q == StD5);
  assign bus.d5stg_fdivd                 = (state_q == StD5) && dbl_q;
  assign bus.d5stg_fdivs                 = (state_q == StD5) && !dbl_q;
  assign bus.d6stg_fdiv                  = (state_q == StD6);
  assign bus.d7stg_fdiv                  = (state_q == StD7);
  assign bus.d7stg_fdivd                 = (state_q == StD7) && dbl_q;
  assign bus.div_iter                    = (state_q == StIter);
  // Pipe clock must already run in the accept cycle so D1 registers can load.
  assign bus.fdiv_clken_l                = !((state_q != StIdle) || bus.inq_div_vld);
  assign bus.div_out_vld                 = vld_q;
  assign bus.div_out_tag                 = tag_q;
endmodule

// File: tb/tb_fpu_div_seq.sv
// Self-checking bench: per-cycle schedule model plus directed latency and hold/reset checks.
module tb_fpu_div_seq;
  localparam int NDbl = 55;
  localparam int NSng = 26;

  logic rclk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_pass = 0;

  fpu_div_seq_if #(.TAG_W(5)) bus ();

  fpu_div_seq #(.ITER_DBL(NDbl), .ITER_SNG(NSng), .TAG_W(5)) dut (
    .rclk  (rclk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 rclk = ~rclk;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [24:0] act_vec();
    return {bus.div_busy, bus.d1stg_step, bus.div_expadd1_in1_dbl, bus.div_expadd1_in1_sng,
            bus.div_expadd1_in2_exp_in2_dbl, bus.div_expadd1_in2_exp_in2_sng,
            bus.d234stg_fdiv, bus.d3stg_fdiv, bus.d4stg_fdiv, bus.div_exp1_expadd1,
            bus.div_exp1_load, bus.d5stg_fdiva, bus.d5stg_fdivd, bus.d5stg_fdivs,
            bus.d6stg_fdiv, bus.d7stg_fdiv, bus.d7stg_fdivd, bus.div_iter, bus.fdiv_clken_l,
            bus.div_out_vld, bus.div_out_vld ? bus.div_out_tag : 5'h0};
  endfunction

  // Model: an op is described by its cycle offset k from the accept edge.
  bit       m_init = 0;
  bit       m_busy = 0;
  int       m_k, m_n;
  bit       m_dbl;
  bit [4:0] m_tag;

  always @(negedge rclk) begin
    bit s1, s2, s3, s4, it, s5, s6, s7, dn, acc;
    logic [24:0] exp_v;
    if (m_init) begin
      s1  = m_busy && m_k == 1;
      s2  = m_busy && m_k == 2;
      s3  = m_busy && m_k == 3;
      s4  = m_busy && m_k == 4;
      it  = m_busy && m_k >= 5 && m_k < 5 + m_n;
      s5  = m_busy && m_k == 5 + m_n;
      s6  = m_busy && m_k == 6 + m_n;
      s7  = m_busy && m_k == 7 + m_n;
      dn  = m_busy && m_k >= 8 + m_n;
      acc = !m_busy && bus.inq_div_vld;
      exp_v = {m_busy, acc, s1 && m_dbl, s1 && !m_dbl, s2 && m_dbl, s2 && !m_dbl,
               s2 || s3 || s4, s3, s4, s1 || s2 || s3 || s4, s1 || s2 || s3 || s4,
               s5, s5 && m_dbl, s5 && !m_dbl, s6, s7, s7 && m_dbl, it,
               !(m_busy || bus.inq_div_vld), dn, dn ? m_tag : 5'h0};
      check("cycle_outputs", act_vec(), exp_v);
    end
    if (reset) begin
      m_init = 1;
      m_busy = 0;
    end else if (m_init) begin
      if (!m_busy) begin
        if (bus.inq_div_vld) begin
          m_busy = 1;
          m_k    = 1;
          m_dbl  = bus.inq_div_dbl;
          m_tag  = bus.inq_div_tag;
          m_n    = bus.inq_div_special ? 0 : (bus.inq_div_dbl ? NDbl : NSng);
        end
      end else if (m_k >= 8 + m_n && bus.div_out_rdy) begin
        m_busy = 0;
      end else begin
        m_k++;
      end
    end
  end

  int lat, iters, nvld, c_d3, c_d5, c_d7d, d1_busy;
  bit d7d_seen;

  // Runs one op from idle; hold = cycles of vld with rdy low; pend raises a request in DONE.
  task automatic run_op(input bit dbl, input bit spc, input bit [4:0] tag, input int hold,
                        input bit pend);
    int nh;
    lat = -1; iters = 0; nvld = 0; c_d3 = -1; c_d5 = -1; c_d7d = -1; d7d_seen = 0;
    d1_busy = 0; nh = 0;
    @(posedge rclk); #1;
    bus.inq_div_vld = 0;
    bus.div_out_rdy = (hold == 0);
    @(negedge rclk);
    check("idle_clken_l", bus.fdiv_clken_l, 1);
    @(posedge rclk); #1;
    bus.inq_div_vld = 1; bus.inq_div_dbl = dbl; bus.inq_div_special = spc;
    bus.inq_div_tag = tag;
    @(negedge rclk);
    check("accept_d1stg_step", bus.d1stg_step, 1);
    check("accept_clken_l", bus.fdiv_clken_l, 0);
    @(posedge rclk); #1;
    bus.inq_div_vld = 0;
    for (int cyc = 1; cyc < 300; cyc++) begin
      @(negedge rclk);
      if (bus.d3stg_fdiv && c_d3 < 0) c_d3 = cyc;
      if ((bus.d5stg_fdivd || bus.d5stg_fdivs) && c_d5 < 0) c_d5 = cyc;
      if (bus.d7stg_fdivd && c_d7d < 0) c_d7d = cyc;
      if (bus.d7stg_fdivd) d7d_seen = 1;
      if (bus.div_iter) iters++;
      if (bus.div_busy && bus.d1stg_step) d1_busy++;
      if (bus.div_out_vld) begin
        nvld++;
        if (lat < 0) lat = cyc;
        if (nh < hold) nh++;
      end
      if (!bus.div_busy && lat >= 0) begin
        if (pend) check("pending_accept_after_rdy", bus.d1stg_step, 1);
        return;
      end
      @(posedge rclk); #1;
      if (pend && lat >= 0) begin
        bus.inq_div_vld = 1; bus.inq_div_dbl = 0; bus.inq_div_special = 1;
        bus.inq_div_tag = 5'h15;
      end
      if (nh >= hold) bus.div_out_rdy = 1;
    end
    check("op_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      @(negedge rclk);
      if (!bus.div_busy) return;
    end
    check("wait_idle_timeout", 0, 1);
  endtask

  initial begin
    bus.inq_div_vld = 0; bus.inq_div_dbl = 0; bus.inq_div_special = 0;
    bus.inq_div_tag = 5'h0; bus.div_out_rdy = 1;
    repeat (3) @(posedge rclk);
    #1 reset = 0;
    @(negedge rclk);
    check("reset_state", act_vec(), 25'h0_0004_0 >> 0 == 25'h40 ? 25'h40 : act_vec() ^ 1);

    // Double, non-special, tag 0A.
    run_op(1, 0, 5'h0A, 0, 0);
    check("dbl_latency", lat, 63);
    check("dbl_iters", iters, 55);
    check("dbl_d3_cycle", c_d3, 3);
    check("dbl_d5_cycle", c_d5, 60);
    check("dbl_d7d_cycle", c_d7d, 62);
    check("dbl_vld_cycles", nvld, 1);

    // Single, non-special.
    run_op(0, 0, 5'h13, 0, 0);
    check("sng_latency", lat, 34);
    check("sng_iters", iters, 26);
    check("sng_d5_cycle", c_d5, 31);
    check("sng_d7d_seen", d7d_seen, 0);

    // Special double.
    run_op(1, 1, 5'h1F, 0, 0);
    check("spc_latency", lat, 8);
    check("spc_iters", iters, 0);
    check("spc_d5_cycle", c_d5, 5);

    // Result held 10 cycles with a request pending.
    run_op(0, 1, 5'h07, 10, 1);
    check("hold_vld_cycles", nvld, 11);
    check("hold_no_accept_while_busy", d1_busy, 0);
    @(posedge rclk); #1;
    bus.inq_div_vld = 0;
    wait_idle();

    // Reset in ITER at cycle 20.
    @(posedge rclk); #1;
    bus.inq_div_vld = 1; bus.inq_div_dbl = 1; bus.inq_div_special = 0; bus.inq_div_tag = 5'h03;
    @(posedge rclk); #1;
    bus.inq_div_vld = 0;
    repeat (19) @(posedge rclk);
    #1 reset = 1;
    @(negedge rclk);
    check("rst_in_iter", bus.div_iter, 1);
    @(posedge rclk); #1;
    reset = 0;
    @(negedge rclk);
    check("rst_abort_state", act_vec(), 25'h40);
    begin
      int v = 0;
      for (int i = 0; i < 70; i++) begin
        @(negedge rclk);
        if (bus.div_out_vld) v++;
      end
      check("rst_no_vld", v, 0);
    end
    run_op(1, 0, 5'h0C, 0, 0);
    check("post_rst_latency", lat, 63);

    // Randomized ops checked by the per-cycle model.
    for (int i = 0; i < 20; i++) begin
      run_op(1'($urandom), 1'($urandom_range(0, 3) == 0), 5'($urandom), $urandom_range(0, 3), 0);
    end

    @(posedge rclk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
